// File: rtl/data_mem_responder.sv
// Responder side of the CPU data-memory interface: valid/ready request and response
// channels around a DEPTH x DATA_W RAM, with programmable wait states and range checking.
`timescale 1ns/1ps
module data_mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic [7:0]        err_count
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [7:0]        errcnt_q, errcnt_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              busy_q, busy_d;

    logic              do_access;
    logic              acc_write;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic [IDX_W-1:0]  acc_idx;
    logic              in_range;
    logic              mem_we;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        errcnt_d  = errcnt_q;
        do_access = 1'b0;
        acc_write = wr_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        mem_we    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    wr_d    = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    // With no wait states the access uses the live request, not the latch
                    if (WAIT_CYCLES == 0) begin
                        do_access = 1'b1;
                        acc_write = req_write;
                        acc_addr  = req_addr;
                        acc_wdata = req_wdata;
                        state_d   = S_RESP;
                    end else begin
                        cnt_d   = 4'(WAIT_CYCLES);
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd1) begin
                    do_access = 1'b1;
                    cnt_d     = 4'd0;
                    state_d   = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                    err_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        acc_idx  = acc_addr[IDX_W-1:0];
        in_range = (32'(acc_addr) < DEPTH);

        if (do_access) begin
            if (in_range) begin
                err_d = 1'b0;
                if (acc_write) begin
                    mem_we  = 1'b1;
                    rdata_d = acc_wdata;
                end else begin
                    rdata_d = mem[acc_idx];
                end
            end else begin
                rdata_d  = '0;
                err_d    = 1'b1;
                errcnt_d = sat_inc8(errcnt_q);
            end
        end

        req_ready_d = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_RESP);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            errcnt_q    <= 8'd0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            errcnt_q    <= errcnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Request latch and RAM hold data only; reset leaves them alone, but a write
    // coinciding with reset must not commit.
    always_ff @(posedge clk) begin
        wr_q    <= wr_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        if (mem_we && rst_n) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign busy      = busy_q;
    assign err_count = errcnt_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: instance A (WAIT_CYCLES=2, DEPTH=128) runs the vector table and
// multi-cycle corner cases; instance B (WAIT_CYCLES=0) covers single-cycle latency.
`timescale 1ns/1ps
module tb_data_mem_responder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       req_valid_a = 1'b0, req_write_a = 1'b0, rsp_ready_a = 1'b1;
    logic [7:0] req_addr_a = 8'h00, req_wdata_a = 8'h00;
    logic       req_ready_a, rsp_valid_a, rsp_err_a, busy_a;
    logic [7:0] rsp_rdata_a, err_count_a;

    logic       req_valid_b = 1'b0, req_write_b = 1'b0, rsp_ready_b = 1'b1;
    logic [7:0] req_addr_b = 8'h00, req_wdata_b = 8'h00;
    logic       req_ready_b, rsp_valid_b, rsp_err_b, busy_b;
    logic [7:0] rsp_rdata_b, err_count_b;

    data_mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(128), .WAIT_CYCLES(2)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_a), .req_ready(req_ready_a), .req_write(req_write_a),
        .req_addr(req_addr_a), .req_wdata(req_wdata_a),
        .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready_a), .rsp_rdata(rsp_rdata_a),
        .rsp_err(rsp_err_a), .busy(busy_a), .err_count(err_count_a)
    );

    data_mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_b), .req_ready(req_ready_b), .req_write(req_write_b),
        .req_addr(req_addr_b), .req_wdata(req_wdata_b),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_rdata(rsp_rdata_b),
        .rsp_err(rsp_err_b), .busy(busy_b), .err_count(err_count_b)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one request on instance A; called #1 after an edge with A idle.
    // n = edges after the accept edge before rsp_valid is seen high.
    task automatic xact_a(input logic w, input logic [7:0] a, input logic [7:0] d,
                          output logic [7:0] rd, output logic er, output int n);
        req_valid_a = 1'b1; req_write_a = w; req_addr_a = a; req_wdata_a = d;
        @(posedge clk); #1;
        req_valid_a = 1'b0; req_addr_a = ~a; req_wdata_a = ~d; req_write_a = ~w;
        n = 0;
        while (rsp_valid_a !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        rd = rsp_rdata_a;
        er = rsp_err_a;
        if (rsp_ready_a) begin
            @(posedge clk); #1;
        end
    endtask

    typedef struct {
        logic       w;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
        logic       exp_err;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t vecs [11];

    initial begin
        logic [7:0] rd;
        logic       er;
        int         n;
        int         bad;
        logic [7:0] exp_cnt;

        vecs[0]  = '{1'b1, 8'h00, 8'h77, 8'h77, 1'b0, 8'd0};
        vecs[1]  = '{1'b1, 8'h10, 8'hA5, 8'hA5, 1'b0, 8'd0};
        vecs[2]  = '{1'b0, 8'h10, 8'h00, 8'hA5, 1'b0, 8'd0};
        vecs[3]  = '{1'b1, 8'h80, 8'h3C, 8'h00, 1'b1, 8'd1};
        vecs[4]  = '{1'b0, 8'h80, 8'h00, 8'h00, 1'b1, 8'd2};
        vecs[5]  = '{1'b0, 8'h00, 8'h00, 8'h77, 1'b0, 8'd2};
        vecs[6]  = '{1'b1, 8'h7F, 8'hC3, 8'hC3, 1'b0, 8'd2};
        vecs[7]  = '{1'b0, 8'h7F, 8'h00, 8'hC3, 1'b0, 8'd2};
        vecs[8]  = '{1'b1, 8'h11, 8'h5A, 8'h5A, 1'b0, 8'd2};
        vecs[9]  = '{1'b0, 8'h11, 8'h00, 8'h5A, 1'b0, 8'd2};
        vecs[10] = '{1'b0, 8'hFF, 8'h00, 8'h00, 1'b1, 8'd3};

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset values
        chk("rst_req_ready", req_ready_a, 1);
        chk("rst_rsp_valid", rsp_valid_a, 0);
        chk("rst_rsp_rdata", rsp_rdata_a, 0);
        chk("rst_rsp_err", rsp_err_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_err_count", err_count_a, 0);
        chk("rst_b_ready", req_ready_b, 1);
        chk("rst_b_busy", busy_b, 0);

        // Zero-wait instance: response visible right after the accept edge, busy one cycle
        req_valid_b = 1'b1; req_write_b = 1'b1; req_addr_b = 8'h10; req_wdata_b = 8'hA5;
        @(posedge clk); #1;
        req_valid_b = 1'b0; req_wdata_b = 8'h00;
        chk("b_wr_valid", rsp_valid_b, 1);
        chk("b_wr_busy", busy_b, 1);
        chk("b_wr_rdata", rsp_rdata_b, 8'hA5);
        @(posedge clk); #1;
        chk("b_wr_busy_end", busy_b, 0);
        req_valid_b = 1'b1; req_write_b = 1'b0; req_addr_b = 8'h10;
        @(posedge clk); #1;
        req_valid_b = 1'b0; req_addr_b = 8'h00;
        chk("b_rd_valid", rsp_valid_b, 1);
        chk("b_rd_busy", busy_b, 1);
        chk("b_rd_rdata", rsp_rdata_b, 8'hA5);
        chk("b_rd_ready_low", req_ready_b, 0);
        @(posedge clk); #1;
        chk("b_rd_busy_end", busy_b, 0);
        chk("b_rd_valid_end", rsp_valid_b, 0);
        chk("b_rd_ready_back", req_ready_b, 1);

        // Vector table on instance A
        for (int i = 0; i < 11; i++) begin
            xact_a(vecs[i].w, vecs[i].addr, vecs[i].wdata, rd, er, n);
            chk($sformatf("v%0d_latency", i), n, 2);
            chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("v%0d_err", i), er, vecs[i].exp_err);
            chk($sformatf("v%0d_err_count", i), err_count_a, vecs[i].exp_cnt);
            chk($sformatf("v%0d_err_cleared", i), rsp_err_a, 0);
            chk($sformatf("v%0d_rdata_kept", i), rsp_rdata_a, vecs[i].exp_rdata);
            chk($sformatf("v%0d_idle", i), {req_ready_a, rsp_valid_a, busy_a}, 3'b100);
        end

        // Backpressure: response held, no new accept despite a pending request
        rsp_ready_a = 1'b0;
        xact_a(1'b0, 8'h10, 8'h00, rd, er, n);
        chk("bp_latency", n, 2);
        chk("bp_rdata", rd, 8'hA5);
        req_valid_a = 1'b1; req_write_a = 1'b1; req_addr_a = 8'h10; req_wdata_a = 8'h00;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (!(rsp_valid_a === 1'b1 && rsp_rdata_a === 8'hA5 && req_ready_a === 1'b0))
                bad++;
        end
        chk("bp_hold_bad_cycles", bad, 0);
        req_valid_a = 1'b0; rsp_ready_a = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_ready", req_ready_a, 1);
        chk("bp_release_valid", rsp_valid_a, 0);
        xact_a(1'b0, 8'h10, 8'h00, rd, er, n);
        chk("bp_no_write", rd, 8'hA5);

        // Reset while in WAIT abandons a pending write
        xact_a(1'b1, 8'h20, 8'h99, rd, er, n);
        req_valid_a = 1'b1; req_write_a = 1'b1; req_addr_a = 8'h20; req_wdata_a = 8'h55;
        @(posedge clk); #1;
        req_valid_a = 1'b0;
        chk("rw_in_wait_busy", busy_a, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rw_state", {req_ready_a, rsp_valid_a, busy_a, rsp_err_a}, 4'b1000);
        chk("rw_rdata", rsp_rdata_a, 0);
        chk("rw_err_count", err_count_a, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("rw_still_idle", {req_ready_a, rsp_valid_a, busy_a}, 3'b100);
        xact_a(1'b0, 8'h20, 8'h00, rd, er, n);
        chk("rw_old_data", rd, 8'h99);

        // Reset while in RESP keeps the committed write
        rsp_ready_a = 1'b0;
        xact_a(1'b1, 8'h21, 8'h66, rd, er, n);
        chk("rr_rdata", rd, 8'h66);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; rsp_ready_a = 1'b1;
        chk("rr_dropped", rsp_valid_a, 0);
        xact_a(1'b0, 8'h21, 8'h00, rd, er, n);
        chk("rr_kept_data", rd, 8'h66);

        // err_count saturation over 300 out-of-range requests
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            xact_a(1'(i % 2), 8'(8'h80 + (i % 128)), 8'(i), rd, er, n);
            exp_cnt = (i + 1 > 255) ? 8'hFF : 8'(i + 1);
            if (err_count_a !== exp_cnt || er !== 1'b1 || rd !== 8'h00) bad++;
        end
        chk("sat_bad_steps", bad, 0);
        chk("sat_final", err_count_a, 8'hFF);
        xact_a(1'b0, 8'h7F, 8'h00, rd, er, n);
        chk("sat_ram_intact", rd, 8'hC3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
